// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings and control-bundle types for the RISC-V pipeline controller.
package riscv_ctrl_pkg;

  localparam int ALUCTL_W = 3;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluCtl_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immSrc_e;

  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } resultSrc_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_e;

  // Everything an instruction needs once it has left decode.
  typedef struct packed {
    logic       regWrite;
    resultSrc_e resultSrc;
    logic       memWrite;
    logic       jump;
    logic       branch;
    aluCtl_e    aluCtl;
    logic       aluSrc;
  } ctrlE_t;

  typedef struct packed {
    logic       regWrite;
    resultSrc_e resultSrc;
    logic       memWrite;
  } ctrlM_t;

  typedef struct packed {
    logic       regWrite;
    resultSrc_e resultSrc;
  } ctrlW_t;

  // funct3/funct7 to ALU operation for R-type and I-type ALU instructions.
  // Only R-type can select subtract; addi with bit 30 set is still add.
  function automatic aluCtl_e aluDecode(input logic [2:0] funct3,
                                        input logic       funct7b5,
                                        input logic       isRType);
    aluCtl_e sel;
    case (funct3)
      3'b000:  sel = (isRType && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  sel = ALU_SLT;
      3'b110:  sel = ALU_OR;
      3'b111:  sel = ALU_AND;
      default: sel = ALU_ADD;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Datapath <-> controller signal bundle. The datapath is the master: it
// supplies the instruction, zero flag and pipelined register indices and
// consumes the controls and hazard signals.
interface pipeline_ctrl_if #(
  parameter int ALUCTL_W = riscv_ctrl_pkg::ALUCTL_W
);
  logic [31:0]         InstrD;
  logic                ZeroE;
  logic [4:0]          Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]          ImmSrcD;
  logic                ALUSrcE;
  logic [ALUCTL_W-1:0] ALUControlE;
  logic                PCSrcE;
  logic                MemWriteM;
  logic                RegWriteW;
  logic [1:0]          ResultSrcW;
  logic                StallF, StallD, FlushD, FlushE;
  logic [1:0]          ForwardAE, ForwardBE;

  modport master (
    output InstrD, ZeroE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW,
           ResultSrcW, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );

  modport slave (
    input  InstrD, ZeroE, Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output ImmSrcD, ALUSrcE, ALUControlE, PCSrcE, MemWriteM, RegWriteW,
           ResultSrcW, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE
  );
endinterface

// File: rtl/hazard_unit.sv
// Combinational forwarding selection and load-use stall / control-hazard
// flush generation. Register x0 never forwards and never stalls.
module hazard_unit
  import riscv_ctrl_pkg::*;
(
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  Rs1E,
  input  logic [4:0]  Rs2E,
  input  logic [4:0]  RdE,
  input  logic [4:0]  RdM,
  input  logic [4:0]  RdW,
  input  resultSrc_e  ResultSrcE,
  input  logic        RegWriteM,
  input  logic        RegWriteW,
  input  logic        PCSrcE,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushD,
  output logic        FlushE,
  output logic [1:0]  ForwardAE,
  output logic [1:0]  ForwardBE
);

  logic lwStall;

  // Memory stage is younger than writeback, so it wins when both match.
  function automatic forward_e fwdSel(input logic [4:0] rs,
                                      input logic [4:0] rdM,
                                      input logic       regWriteM,
                                      input logic [4:0] rdW,
                                      input logic       regWriteW);
    forward_e sel;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs))
      sel = FWD_M;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs))
      sel = FWD_W;
    else
      sel = FWD_RF;
    return sel;
  endfunction

  // Operand source selection for both ALU inputs.
  always_comb begin
    ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

  // A load in E whose destination is read by D must hold F/D and bubble E.
  // A taken branch/jump cannot coexist with a load in E, so no priority.
  always_comb begin
    lwStall = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
              ((Rs1D == RdE) || (Rs2D == RdE));
    StallF  = lwStall;
    StallD  = lwStall;
    FlushD  = PCSrcE;
    FlushE  = lwStall | PCSrcE;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Main decoder plus the E/M/W control pipeline for a five-stage RISC-V core.
// Forwarding and stall logic lives in hazard_unit.
module pipeline_ctrl #(
  parameter int ALUCTL_W = riscv_ctrl_pkg::ALUCTL_W
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
);
  import riscv_ctrl_pkg::*;

  logic [6:0] opD;
  logic [2:0] funct3D;
  logic       funct7b5D;
  ctrlE_t     decD;
  immSrc_e    immSrcD;
  ctrlE_t     ctrlE_p0;
  ctrlM_t     ctrlM_p1;
  ctrlW_t     ctrlW_p2;
  logic       pcSrcE;

  assign opD       = bus.InstrD[6:0];
  assign funct3D   = bus.InstrD[14:12];
  assign funct7b5D = bus.InstrD[30];

  // Decode: unknown opcodes fall through to an all-zero bubble.
  always_comb begin
    decD    = '0;
    immSrcD = IMM_I;
    case (opD)
      OP_LW: begin
        decD.regWrite  = 1'b1;
        decD.resultSrc = RES_MEM;
        decD.aluSrc    = 1'b1;
      end
      OP_SW: begin
        decD.memWrite = 1'b1;
        decD.aluSrc   = 1'b1;
        immSrcD       = IMM_S;
      end
      OP_RTYP: begin
        decD.regWrite = 1'b1;
        decD.aluCtl   = aluDecode(funct3D, funct7b5D, 1'b1);
      end
      OP_IALU: begin
        decD.regWrite = 1'b1;
        decD.aluSrc   = 1'b1;
        decD.aluCtl   = aluDecode(funct3D, funct7b5D, 1'b0);
      end
      OP_BEQ: begin
        decD.branch = 1'b1;
        decD.aluCtl = ALU_SUB;
        immSrcD     = IMM_B;
      end
      OP_JAL: begin
        decD.regWrite  = 1'b1;
        decD.jump      = 1'b1;
        decD.resultSrc = RES_PC4;
        immSrcD        = IMM_J;
      end
      default: ;
    endcase
  end

  // D -> E: a flush (load-use bubble or taken branch/jump) loads a bubble.
  always_ff @(posedge clk) begin
    if (reset || bus.FlushE)
      ctrlE_p0 <= '0;
    else
      ctrlE_p0 <= decD;
  end

  // E -> M: never stalled or flushed.
  always_ff @(posedge clk) begin
    if (reset)
      ctrlM_p1 <= '0;
    else
      ctrlM_p1 <= '{regWrite:  ctrlE_p0.regWrite,
                    resultSrc: ctrlE_p0.resultSrc,
                    memWrite:  ctrlE_p0.memWrite};
  end

  // M -> W: never stalled or flushed.
  always_ff @(posedge clk) begin
    if (reset)
      ctrlW_p2 <= '0;
    else
      ctrlW_p2 <= '{regWrite:  ctrlM_p1.regWrite,
                    resultSrc: ctrlM_p1.resultSrc};
  end

  assign pcSrcE = ctrlE_p0.jump | (ctrlE_p0.branch & bus.ZeroE);

  assign bus.ImmSrcD     = immSrcD;
  assign bus.ALUSrcE     = ctrlE_p0.aluSrc;
  assign bus.ALUControlE = ALUCTL_W'(ctrlE_p0.aluCtl);
  assign bus.PCSrcE      = pcSrcE;
  assign bus.MemWriteM   = ctrlM_p1.memWrite;
  assign bus.RegWriteW   = ctrlW_p2.regWrite;
  assign bus.ResultSrcW  = ctrlW_p2.resultSrc;

  hazard_unit uHazard (
    .Rs1D       (bus.Rs1D),
    .Rs2D       (bus.Rs2D),
    .Rs1E       (bus.Rs1E),
    .Rs2E       (bus.Rs2E),
    .RdE        (bus.RdE),
    .RdM        (bus.RdM),
    .RdW        (bus.RdW),
    .ResultSrcE (ctrlE_p0.resultSrc),
    .RegWriteM  (ctrlM_p1.regWrite),
    .RegWriteW  (ctrlW_p2.regWrite),
    .PCSrcE     (pcSrcE),
    .StallF     (bus.StallF),
    .StallD     (bus.StallD),
    .FlushD     (bus.FlushD),
    .FlushE     (bus.FlushE),
    .ForwardAE  (bus.ForwardAE),
    .ForwardBE  (bus.ForwardBE)
  );

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: ALUCTL_W, default 3, width of ALUControl encoding.
REQ-002 Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 InstrD  in  32  decode-stage instruction; fields used are op[6:0], funct3[14:12] and funct7b5[30].
REQ-006 ZeroE  in  1  ALU zero flag, execute stage.
REQ-007 Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW  in  5 each  register indices from the datapath pipeline.
REQ-008 ImmSrcD  out  2  immediate format: 00 I, 01 S, 10 B, 11 J.
REQ-009 ALUSrcE  out  1; ALUControlE  out  ALUCTL_W; PCSrcE  out  1  execute-stage controls.
REQ-010 MemWriteM  out  1  data memory write enable, memory stage.
REQ-011 RegWriteW  out  1; ResultSrcW  out  2 (00 ALU, 01 memory, 10 PC+4)  writeback controls.
REQ-012 StallF, StallD, FlushD, FlushE  out  1 each; ForwardAE, ForwardBE  out  2 each (00 register file, 01 ResultW, 10 ALUResultM).

Function
REQ-013 Decode: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111; any other opcode produces all-zero controls (bubble).
REQ-014 ALUControl: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- lw, sw and jal use add; beq uses sub.
- R/I funct3 mapping: 000 gives sub only when R-type and funct7b5=1, otherwise add; 010 slt; 110 or; 111 and; other funct3 values give add.
REQ-015 ImmSrcD is combinational from InstrD in the same cycle; all other decoded controls register into the E stage at the clk edge.
REQ-016 Control pipeline is D->E->M->W, one register per stage.
- E holds RegWrite, ResultSrc, MemWrite, Jump, Branch, ALUControl, ALUSrc.
- M holds RegWrite, ResultSrc, MemWrite.
- W holds RegWrite, ResultSrc.
REQ-017 PCSrcE = JumpE | (BranchE & ZeroE), combinational.
REQ-018 ForwardAE = 10 if RegWriteM and RdM!=0 and RdM==Rs1E; else 01 if RegWriteW and RdW!=0 and RdW==Rs1E; else 00; M has priority over W. ForwardBE uses the same rule with Rs2E.
REQ-019 lwStall = (ResultSrcE==01) and RdE!=0 and (Rs1D==RdE or Rs2D==RdE).
REQ-020 StallF = StallD = lwStall; FlushD = PCSrcE; FlushE = lwStall | PCSrcE.
REQ-021 When FlushE=1, the E-stage control registers load zero on the next edge; M and W registers are never stalled or flushed.
REQ-022 lwStall and PCSrcE are mutually exclusive, since only one instruction occupies E; no priority logic is needed between them.
REQ-023 Writes to x0 never cause forwarding or stall.
REQ-024 Forwarding and hazard outputs are combinational, with zero-cycle latency from the pipeline indices.

Reset
REQ-025 While reset=1, every control pipeline register clears to zero on the clk edge.
REQ-026 After reset: RegWriteW=0, MemWriteM=0, ResultSrcW=00, PCSrcE=0, ALUControlE=000, ALUSrcE=0.
REQ-027 Hazard outputs after reset follow the cleared state: StallF=StallD=FlushD=FlushE=0, ForwardAE=ForwardBE=00.
REQ-028 Reset asserted mid-operation discards all in-flight controls within one cycle; no partial writes occur after the reset edge.

Structure
REQ-029 Shared package riscv_ctrl_pkg holds:
- opcode constants;
- ALUControl, ImmSrc, ResultSrc and Forward encodings;
- ALUCTL_W.
REQ-030 Forwarding and stall logic is the sub-module hazard_unit (combinational); decode and control pipeline registers live in pipeline_ctrl.

Verification
REQ-031 Sequence add x5,x1,x2 then sub x6,x5,x3 -> during sub in E, ForwardAE=10 and ForwardBE=00.
REQ-032 Sequence add x5; nop; or x7,x0,x5 -> during or in E, ForwardBE=01.
REQ-033 Sequence lw x4,0(x0) then add x8,x4,x4 -> exactly one cycle with StallF=StallD=FlushE=1; the following cycle has ForwardAE=ForwardBE=01.
REQ-034 beq with ZeroE=1 in E -> PCSrcE=1, FlushD=1, FlushE=1; the next cycle has RegWriteW, MemWriteM and BranchE control of the flushed slots all 0.
REQ-035 Sequence lw x0,... then add x1,x0,x0 -> no stall; a write to x0 in M -> ForwardAE=00.
REQ-036 Reset asserted with sw in M -> MemWriteM=0 on the first edge with reset=1; illegal opcode 1111111 -> RegWriteW=0 and MemWriteM=0 three cycles later.
